// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter: programmable modulus, parallel load with clamp,
// wrap-or-saturate overflow, and an explicit IDLE/UP/DOWN/HALT direction FSM.
module mod_updown_counter #(
  parameter int NBIT = 5,
  parameter int MAX  = 2**NBIT - 1,
  parameter int WRAP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            up_down,
  input  logic            load,
  input  logic [NBIT-1:0] load_val,
  output logic [NBIT-1:0] q,
  output logic            tc,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [NBIT-1:0] L_MAX  = MAX[NBIT-1:0];
  localparam logic [NBIT-1:0] L_ZERO = '0;
  localparam logic [NBIT-1:0] L_ONE  = {{(NBIT-1){1'b0}}, 1'b1};
  localparam bit              L_WRAP = (WRAP != 0);

  state_t          r_state;
  logic [NBIT-1:0] r_q;
  logic            r_tc;

  state_t          w_state_next;
  logic [NBIT-1:0] w_q_next;
  logic            w_tc_next;

  logic [NBIT-1:0] w_load_clamped;
  logic            w_at_max;
  logic            w_at_zero;
  logic            w_count;

  assign w_load_clamped = (load_val > L_MAX) ? L_MAX : load_val;
  assign w_at_max       = (r_q == L_MAX);
  assign w_at_zero      = (r_q == L_ZERO);
  assign w_count        = en && (r_state != ST_HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_q     <= L_ZERO;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_tc    <= w_tc_next;
    end
  end

  // tc defaults low so it only ever lasts the one cycle after a wrap or HALT entry.
  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_tc_next    = 1'b0;
    if (load) begin
      w_state_next = ST_IDLE;
      w_q_next     = w_load_clamped;
    end else if (w_count) begin
      if (up_down) begin
        w_state_next = ST_UP;
        if (!w_at_max) begin
          w_q_next = r_q + L_ONE;
        end else begin
          w_tc_next = 1'b1;
          if (L_WRAP) begin
            w_q_next = L_ZERO;
          end else begin
            w_state_next = ST_HALT;
          end
        end
      end else begin
        w_state_next = ST_DOWN;
        if (!w_at_zero) begin
          w_q_next = r_q - L_ONE;
        end else begin
          w_tc_next = 1'b1;
          if (L_WRAP) begin
            w_q_next = L_MAX;
          end else begin
            w_state_next = ST_HALT;
          end
        end
      end
    end
  end

  always_comb begin
    q     = r_q;
    tc    = r_tc;
    state = r_state;
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three instances (MAX=20 wrap, MAX=31 saturate, MAX=1 wrap)
// share stimulus; directed test-plan checks plus a random run against an integer model.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_down = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_val = '0;

  logic [4:0] q_o  [3];
  logic       tc_o [3];
  logic [1:0] st_o [3];

  int errors = 0;
  int checks = 0;

  int max_v  [3] = '{20, 31, 1};
  int wrap_v [3] = '{1, 0, 1};
  int mq [3];
  int mt [3];
  int ms [3];

  always #5 clk = ~clk;

  mod_updown_counter #(.NBIT(5), .MAX(20), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .q(q_o[0]), .tc(tc_o[0]), .state(st_o[0]));

  mod_updown_counter #(.NBIT(5), .MAX(31), .WRAP(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .q(q_o[1]), .tc(tc_o[1]), .state(st_o[1]));

  mod_updown_counter #(.NBIT(5), .MAX(1), .WRAP(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .q(q_o[2]), .tc(tc_o[2]), .state(st_o[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: states IDLE=0 UP=1 DOWN=2 HALT=3, values as plain integers modulo max+1.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        mq[k] = 0; mt[k] = 0; ms[k] = 0;
      end else if (load) begin
        mq[k] = (int'(load_val) > max_v[k]) ? max_v[k] : int'(load_val);
        mt[k] = 0; ms[k] = 0;
      end else if (en && ms[k] != 3) begin
        if (up_down) begin
          ms[k] = 1;
          mt[k] = (mq[k] == max_v[k]) ? 1 : 0;
          if (mq[k] < max_v[k] || wrap_v[k] != 0) mq[k] = (mq[k] + 1) % (max_v[k] + 1);
          else ms[k] = 3;
        end else begin
          ms[k] = 2;
          mt[k] = (mq[k] == 0) ? 1 : 0;
          if (mq[k] > 0 || wrap_v[k] != 0) mq[k] = (mq[k] + max_v[k]) % (max_v[k] + 1);
          else ms[k] = 3;
        end
      end else begin
        mt[k] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mdl_q[%0d]", k), 32'(q_o[k]), mq[k]);
      chk($sformatf("mdl_tc[%0d]", k), 32'(tc_o[k]), mt[k]);
      chk($sformatf("mdl_st[%0d]", k), 32'(st_o[k]), ms[k]);
    end
    $display("t=%0t rst=%0b ld=%0b lv=%0d en=%0b ud=%0b | a q=%0d tc=%0b st=%0d | b q=%0d tc=%0b st=%0d | c q=%0d tc=%0b st=%0d",
             $time, rst, load, load_val, en, up_down, q_o[0], tc_o[0], st_o[0],
             q_o[1], tc_o[1], st_o[1], q_o[2], tc_o[2], st_o[2]);
  endtask

  task automatic drive(input logic r, input logic l, input logic [4:0] lv,
                       input logic e, input logic ud);
    rst = r; load = l; load_val = lv; en = e; up_down = ud;
  endtask

  initial begin
    int exp_q [6];
    int exp_tc [6];
    int exp_b_st [4];
    for (int k = 0; k < 3; k++) begin mq[k] = 0; mt[k] = 0; ms[k] = 0; end

    // Reset
    drive(1'b0, 1'b1, 5'd9, 1'b1, 1'b1);
    step();
    chk("rst_q_a", 32'(q_o[0]), 0);
    chk("rst_tc_a", 32'(tc_o[0]), 0);
    chk("rst_st_a", 32'(st_o[0]), 0);

    // Up-count through the MAX=20 wrap
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    for (int i = 0; i < 23; i++) begin
      step();
      chk($sformatf("up_q_a[%0d]", i), 32'(q_o[0]), (i + 1) % 21);
      chk($sformatf("up_tc_a[%0d]", i), 32'(tc_o[0]), (i == 20) ? 1 : 0);
      chk($sformatf("up_st_a[%0d]", i), 32'(st_o[0]), 1);
    end

    // Down wrap then direction flip from q=2
    drive(1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
    step();
    exp_q  = '{1, 0, 20, 19, 20, 0};
    exp_tc = '{0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 5'd0, 1'b1, (i >= 4) ? 1'b1 : 1'b0);
      step();
      chk($sformatf("dn_q_a[%0d]", i), 32'(q_o[0]), exp_q[i]);
      chk($sformatf("dn_tc_a[%0d]", i), 32'(tc_o[0]), exp_tc[i]);
      chk($sformatf("dn_st_a[%0d]", i), 32'(st_o[0]), (i >= 4) ? 1 : 2);
    end

    // Saturate on the MAX=31 non-wrapping instance
    drive(1'b1, 1'b1, 5'd30, 1'b0, 1'b1);
    step();
    exp_b_st = '{1, 3, 3, 3};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
      step();
      chk($sformatf("sat_q_b[%0d]", i), 32'(q_o[1]), 31);
      chk($sformatf("sat_st_b[%0d]", i), 32'(st_o[1]), exp_b_st[i]);
      chk($sformatf("sat_tc_b[%0d]", i), 32'(tc_o[1]), (i == 1) ? 1 : 0);
    end
    drive(1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    step();
    chk("unhalt_q_b", 32'(q_o[1]), 5);
    chk("unhalt_st_b", 32'(st_o[1]), 0);
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    chk("resume_q_b", 32'(q_o[1]), 4);
    chk("resume_st_b", 32'(st_o[1]), 2);

    // Load priority over en, with clamp
    drive(1'b1, 1'b1, 5'd31, 1'b1, 1'b1);
    step();
    chk("clamp_q_a", 32'(q_o[0]), 20);
    chk("clamp_st_a", 32'(st_o[0]), 0);
    chk("clamp_tc_a", 32'(tc_o[0]), 0);
    drive(1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    step();
    chk("load7_q_a", 32'(q_o[0]), 7);

    // Hold at q=12 in UP
    drive(1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 5'd0, 1'b0, (i % 2 == 0) ? 1'b0 : 1'b1);
      step();
      chk($sformatf("hold_q_a[%0d]", i), 32'(q_o[0]), 12);
      chk($sformatf("hold_st_a[%0d]", i), 32'(st_o[0]), 1);
      chk($sformatf("hold_tc_a[%0d]", i), 32'(tc_o[0]), 0);
    end

    // Mid-count reset at q=9, then reset out of HALT
    drive(1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    chk("pre_rst_q_a", 32'(q_o[0]), 9);
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    chk("mid_rst_q_a", 32'(q_o[0]), 0);
    chk("mid_rst_st_a", 32'(st_o[0]), 0);
    drive(1'b1, 1'b1, 5'd31, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    chk("halt_st_b", 32'(st_o[1]), 3);
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    chk("halt_rst_q_b", 32'(q_o[1]), 0);
    chk("halt_rst_st_b", 32'(st_o[1]), 0);
    chk("halt_rst_tc_b", 32'(tc_o[1]), 0);
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    chk("post_rst_q_a", 32'(q_o[0]), 1);
    chk("post_rst_q_b", 32'(q_o[1]), 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
